clk_ena_gen: RTL and testbench
==============================

CLK_ENA_GEN -- requirements
Module: clk_ena_gen

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of independent clock-enable channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of divider/fraction operands.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports clk and aclr.
REQ-004 SHALL have ports, in this order:
- clk  in  1  system clock
- aclr  in  1  async reset, active high
- sync_ena  in  CH_NUM  per-channel run enable
- wr_valid  in  1  config write request
- wr_ready  out  1  config write accepted this cycle
- wr_ch  in  $clog2(CH_NUM)  target channel
- wr_mode  in  1  0 = integer divide, 1 = fractional (DDA)
- wr_a  in  CNT_WIDTH  cnt_max (integer) or num (fractional)
- wr_b  in  CNT_WIDTH  den (fractional; ignored in integer mode)
- pending  out  CH_NUM  shadow config not yet applied
- clk_ena  out  CH_NUM  one-cycle enable pulses

Function
REQ-005 SHALL hold, per channel, an active config {mode, a, b} and a shadow config; only the active config controls pulse generation.
REQ-006 SHALL drive wr_ready = !pending[wr_ch]; a write is accepted when wr_valid && wr_ready, loads the shadow config and sets pending[wr_ch] on the next edge.
REQ-007 SHALL ignore writes with wr_ch >= CH_NUM (wr_ready = 1, no effect).
REQ-008 SHALL apply the shadow config to the active config, clearing pending, on the first edge at an apply point: sync_ena low; integer-mode wrap (cnt == cnt_max); fractional-mode wrap (acc + num >= den); or fractional num == 0.
REQ-009 SHALL, on an apply that changes mode, clear the counter/accumulator to 0; on an apply without a mode change, leave them unchanged.
REQ-010 SHALL, in integer mode, advance cnt from 0 to cnt_max and then return to 0 while sync_ena is high, and register ena_reg <= (cnt == 0).
REQ-011 SHALL, in fractional mode, use an accumulator acc of CNT_WIDTH+1 bits. Each enabled edge: if acc + num >= den, then acc <= acc + num - den and ena_reg <= 1; otherwise acc <= acc + num and ena_reg <= 0.
REQ-012 SHALL treat fractional num >= den, or den == 0, as a pulse every cycle; num == 0 SHALL produce no pulses.
REQ-013 SHALL hold cnt/acc at 0 and ena_reg at 0 on every edge where sync_ena is low.
REQ-014 SHALL drive clk_ena[i] = sync_ena[i] && ena_reg[i], so deasserting sync_ena suppresses a pulse in the same cycle.
REQ-015 SHALL produce the first pulse in the cycle after the first edge with sync_ena high (latency 1); integer period = cnt_max+1 cycles; fractional mean rate = num/den.
REQ-016 SHALL apply a write accepted on the same edge as an apply point no earlier than the next apply point (shadow load precedes apply).

Reset
REQ-017 SHALL, while aclr is high, clear all cnt, acc, ena_reg and pending, and set active and shadow configs to {integer, 0, 0}.
REQ-018 SHALL give reset values clk_ena = 0 and pending = 0; wr_ready SHALL be 1 after reset.
REQ-019 SHALL, on aclr asserted mid-operation, drop any pending write and clear the in-flight accumulator state.

Structure
REQ-020 SHALL place the mode enum (MODE_INT, MODE_FRAC) and the config struct type in package clk_ena_pkg.
REQ-021 SHALL implement one channel as sub-module clk_ena_chan, instantiated CH_NUM times by generate; write decode and wr_ready SHALL be in the top level.

Verification
REQ-022 SHALL verify integer mode: cnt_max=3, sync_ena rises -> first clk_ena 1 cycle later, then every 4 cycles.
REQ-023 SHALL verify fractional mode: num=3, den=8, 800 cycles -> exactly 300 pulses, spacing 2 or 3 cycles only.
REQ-024 SHALL verify shadow apply: write cnt_max=9 while running cnt_max=3 -> pending=1 until cnt==3, then period 10 with no short or long period.
REQ-025 SHALL verify write rejection: second write to the same channel while pending -> wr_ready=0, first config applied.
REQ-026 SHALL verify num=0 and num=den: num=0 gives no pulses with immediate apply; num=den=5 gives clk_ena high every cycle.
REQ-027 SHALL verify reset: aclr pulse mid-period with pending set -> clk_ena=0 and pending=0 at once; restart behaves as after power-up.

Source files
------------

// File: rtl/clk_ena_pkg.sv
// clk_ena_pkg: mode and per-channel configuration types shared by the clock-enable generator.
package clk_ena_pkg;
    localparam int CFG_W = 32;
    typedef enum logic {MODE_INT = 1'b0, MODE_FRAC = 1'b1} mode_t;
    typedef struct packed {
        mode_t            mode;
        logic [CFG_W-1:0] a;
        logic [CFG_W-1:0] b;
    } cfg_t;
    localparam cfg_t CFG_RST = '{mode: MODE_INT, a: '0, b: '0};
endpackage

// File: rtl/clk_ena_chan.sv
// clk_ena_chan: one enable channel, integer divider or DDA fraction, with shadowed config.
module clk_ena_chan
    import clk_ena_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic clk,
    input  logic aclr,
    input  logic run,
    input  logic load,
    input  cfg_t load_cfg,
    output logic pending,
    output logic clk_ena
);
    localparam int AW = CNT_WIDTH + 1;
    localparam int SW = CNT_WIDTH + 2;
    localparam int CW = (SW > CFG_W) ? SW : CFG_W;
    cfg_t                 active, shadow;
    logic [CNT_WIDTH-1:0] cnt;
    logic [AW-1:0]        acc, acc_next;
    logic [SW-1:0]        sum;
    logic                 ena_reg, is_frac, int_wrap, frac_wrap, num_zero, every, apply;
    always_comb begin
        is_frac   = active.mode == MODE_FRAC;
        int_wrap  = CFG_W'(cnt) == active.a;
        sum       = SW'(acc) + SW'(active.a[CNT_WIDTH-1:0]);
        frac_wrap = CW'(sum) >= CW'(active.b);
        num_zero  = active.a == '0;
        every     = CW'(active.a) >= CW'(active.b);
        acc_next  = frac_wrap ? AW'(sum - SW'(active.b[CNT_WIDTH-1:0])) : AW'(sum);
        apply     = pending && (!run || (is_frac ? (frac_wrap || num_zero) : int_wrap));
        clk_ena   = run && ena_reg;
    end
    // num >= den pulses every cycle; the accumulator is held so it cannot run away
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            active  <= CFG_RST;
            shadow  <= CFG_RST;
            pending <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            ena_reg <= 1'b0;
        end else begin
            if (!run) begin
                cnt     <= '0;
                acc     <= '0;
                ena_reg <= 1'b0;
            end else if (is_frac) begin
                ena_reg <= frac_wrap && !num_zero;
                if (!every) acc <= acc_next;
            end else begin
                ena_reg <= cnt == '0;
                cnt     <= int_wrap ? '0 : cnt + CNT_WIDTH'(1);
            end
            if (load) begin
                shadow  <= load_cfg;
                pending <= 1'b1;
            end
            if (apply) begin
                active  <= shadow;
                pending <= 1'b0;
                if (shadow.mode != active.mode) begin
                    cnt <= '0;
                    acc <= '0;
                end
            end
        end
    end
endmodule

// File: rtl/clk_ena_gen.sv
// clk_ena_gen: CH_NUM independent clock-enable channels sharing one config write port.
module clk_ena_gen
    import clk_ena_pkg::*;
#(
    parameter  int CH_NUM    = 4,
    parameter  int CNT_WIDTH = 16,
    localparam int CHW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic [CH_NUM-1:0]    sync_ena,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [CHW-1:0]       wr_ch,
    input  logic                 wr_mode,
    input  logic [CNT_WIDTH-1:0] wr_a,
    input  logic [CNT_WIDTH-1:0] wr_b,
    output logic [CH_NUM-1:0]    pending,
    output logic [CH_NUM-1:0]    clk_ena
);
    cfg_t wr_cfg;
    logic wr_fire;
    // writes to nonexistent channels are accepted and dropped
    always_comb begin
        wr_ready = (32'(wr_ch) >= CH_NUM) || !pending[wr_ch];
        wr_fire  = wr_valid && wr_ready;
        wr_cfg   = '{mode: mode_t'(wr_mode), a: CFG_W'(wr_a), b: CFG_W'(wr_b)};
    end
    genvar i;
    for (i = 0; i < CH_NUM; i++) begin : g_ch
        clk_ena_chan #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
            .clk      (clk),
            .aclr     (aclr),
            .run      (sync_ena[i]),
            .load     (wr_fire && 32'(wr_ch) == i),
            .load_cfg (wr_cfg),
            .pending  (pending[i]),
            .clk_ena  (clk_ena[i])
        );
    end
endmodule

// File: tb/tb_clk_ena_gen.sv
// tb_clk_ena_gen: scoreboard bench; stimulus queues cycle-tagged expectations, a monitor checks them.
module tb_clk_ena_gen;
    localparam int CH = 3;
    typedef struct {
        int            cyc;
        int            kind;
        string         name;
        logic [CH-1:0] ena;
        logic [CH-1:0] pend;
        logic          rdy;
        int            n;
        int            gmin;
        int            gmax;
    } exp_t;
    logic          clk, aclr, wr_valid, wr_ready, wr_mode;
    logic [CH-1:0] sync_ena, pending, clk_ena;
    logic [1:0]    wr_ch;
    logic [15:0]   wr_a, wr_b;
    exp_t q[$];
    int cyc = 0, n_chk = 0, n_fail = 0;
    int st_on = 0, st_n = 0, st_last = -1, st_min = 0, st_max = 0;

    clk_ena_gen #(.CH_NUM(CH), .CNT_WIDTH(16)) dut (
        .clk(clk), .aclr(aclr), .sync_ena(sync_ena), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_mode(wr_mode), .wr_a(wr_a), .wr_b(wr_b), .pending(pending), .clk_ena(clk_ena)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.kind == 1) begin
                    st_on = 1; st_n = 0; st_last = -1; st_min = 1 << 30; st_max = 0;
                end else begin
                    n_chk++;
                    if (e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL %s: checked at cycle %0d, due at cycle %0d", e.name, cyc, e.cyc);
                    end else if (e.kind == 0) begin
                        if ({clk_ena, pending, wr_ready} !== {e.ena, e.pend, e.rdy}) begin
                            n_fail++;
                            $display("FAIL %s @%0d: clk_ena=%b pending=%b wr_ready=%b, required %b %b %b",
                                     e.name, cyc, clk_ena, pending, wr_ready, e.ena, e.pend, e.rdy);
                        end
                    end else begin
                        st_on = 0;
                        if (st_n != e.n || st_min != e.gmin || st_max != e.gmax) begin
                            n_fail++;
                            $display("FAIL %s @%0d: pulses=%0d gap=%0d..%0d, required %0d gap=%0d..%0d",
                                     e.name, cyc, st_n, st_min, st_max, e.n, e.gmin, e.gmax);
                        end
                    end
                end
            end
            if (st_on != 0 && clk_ena[0]) begin
                if (st_last >= 0) begin
                    if (cyc - st_last < st_min) st_min = cyc - st_last;
                    if (cyc - st_last > st_max) st_max = cyc - st_last;
                end
                st_last = cyc;
                st_n++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic vec(input string nm, input int c, input logic [CH-1:0] e_ena, input logic [CH-1:0] e_pend, input logic e_rdy);
        exp_t e;
        e.cyc = c; e.kind = 0; e.name = nm; e.ena = e_ena; e.pend = e_pend; e.rdy = e_rdy;
        e.n = 0; e.gmin = 0; e.gmax = 0;
        q.push_back(e);
    endtask

    task automatic stat(input string nm, input int c, input int kind, input int n, input int gmin, input int gmax);
        exp_t e;
        e.cyc = c; e.kind = kind; e.name = nm; e.ena = '0; e.pend = '0; e.rdy = 1'b0;
        e.n = n; e.gmin = gmin; e.gmax = gmax;
        q.push_back(e);
    endtask

    task automatic write(input int ch, input logic m, input int a, input int b);
        wr_valid = 1'b1; wr_ch = 2'(ch); wr_mode = m; wr_a = 16'(a); wr_b = 16'(b);
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        int c, m, s, z, e0, r;
        aclr = 1'b1; sync_ena = '0; wr_valid = 1'b0; wr_ch = '0; wr_mode = 1'b0; wr_a = '0; wr_b = '0;
        tick();
        vec("reset", cyc, 3'b000, 3'b000, 1'b1);
        tick(); tick();
        aclr = 1'b0;
        c = cyc;
        vec("bad_ch_rdy", c, 3'b000, 3'b000, 1'b1);
        vec("bad_ch_nop", c + 1, 3'b000, 3'b000, 1'b1);
        write(3, 1'b0, 7, 0);
        c = cyc;
        vec("wr_rdy", c, 3'b000, 3'b000, 1'b1);
        vec("wr_pend", c + 1, 3'b000, 3'b001, 1'b0);
        vec("wr_apply", c + 2, 3'b000, 3'b000, 1'b1);
        write(0, 1'b0, 3, 0);
        wait_to(c + 2);
        m = cyc;
        sync_ena = 3'b001;
        for (int k = 1; k < 10; k++) vec("int3", m + k, (k % 4 == 1) ? 3'b001 : 3'b000, 3'b000, 1'b1);
        wait_to(m + 10);
        for (int k = 10; k < 35; k++)
            vec("shadow", m + k, (k == 13 || k == 23 || k == 33) ? 3'b001 : 3'b000,
                (k == 11) ? 3'b001 : 3'b000, k != 11);
        write(0, 1'b0, 9, 0);
        write(0, 1'b0, 5, 0);
        wait_to(m + 35);
        c = cyc;
        sync_ena = 3'b000;
        vec("frac_pend", c + 1, 3'b000, 3'b001, 1'b0);
        vec("frac_apply", c + 2, 3'b000, 3'b000, 1'b1);
        write(0, 1'b1, 3, 8);
        wait_to(c + 2);
        s = cyc;
        sync_ena = 3'b001;
        stat("frac_clr", s + 1, 1, 0, 0, 0);
        vec("frac_s1", s + 1, 3'b000, 3'b000, 1'b1);
        vec("frac_s2", s + 2, 3'b000, 3'b000, 1'b1);
        vec("frac_s3", s + 3, 3'b001, 3'b000, 1'b1);
        stat("frac_3_8", s + 801, 2, 300, 2, 3);
        wait_to(s + 801);
        z = cyc;
        sync_ena = 3'b000;
        vec("num0_pend", z + 1, 3'b000, 3'b001, 1'b0);
        write(0, 1'b1, 0, 8);
        wait_to(z + 2);
        sync_ena = 3'b001;
        for (int k = 1; k <= 20; k++) vec("num0", z + 2 + k, 3'b000, 3'b000, 1'b1);
        wait_to(z + 22);
        e0 = cyc;
        for (int k = 0; k <= 12; k++)
            vec("num_den", e0 + k, (k >= 3) ? 3'b001 : 3'b000, (k == 1) ? 3'b001 : 3'b000, k != 1);
        write(0, 1'b1, 5, 5);
        wait_to(e0 + 13);
        c = cyc;
        sync_ena = 3'b000;
        write(0, 1'b0, 9, 0);
        wait_to(c + 2);
        r = cyc;
        sync_ena = 3'b001;
        for (int k = 1; k <= 13; k++)
            vec("aclr", r + k, (k == 1 || k >= 9) ? 3'b001 : 3'b000, (k == 5) ? 3'b001 : 3'b000, k != 5);
        wait_to(r + 4);
        write(0, 1'b0, 3, 0);
        wait_to(r + 6);
        aclr = 1'b1;
        wait_to(r + 8);
        aclr = 1'b0;
        wait_to(r + 14);
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations still queued, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
